// File: rtl/edf_preempt_ctrl.sv
// edf_preempt_ctrl: earliest-deadline-first preemption gate between an interrupt controller and a core.
//   clk_i/rst_ni         clock, asynchronous active-low reset
//   ic_valid_i/id/dl     pending winner from the controller; ic_ack_o/ic_ack_id_o claim pulse back
//   core_irq_o/core_id_o offer to core; core_claim_i takes it, core_complete_i ends the top handler
//   active_dl_o/depth_o  top-of-stack deadline and nesting depth; err_o sticky complete-on-empty
module edf_preempt_ctrl #(
   parameter int NrIrqs     = 4,
   parameter int TsWidth    = 24,
   parameter int StackDepth = 4,
   localparam int IdWidth   = $clog2(NrIrqs),
   localparam int DepWidth  = $clog2(StackDepth) + 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                ic_valid_i,
   input  logic [IdWidth-1:0]  ic_id_i,
   input  logic [TsWidth-1:0]  ic_dl_i,
   output logic                ic_ack_o,
   output logic [IdWidth-1:0]  ic_ack_id_o,
   output logic                core_irq_o,
   output logic [IdWidth-1:0]  core_id_o,
   input  logic                core_claim_i,
   input  logic                core_complete_i,
   output logic [TsWidth-1:0]  active_dl_o,
   output logic [DepWidth-1:0] depth_o,
   output logic                err_o
);
   typedef enum logic [1:0] {IDLE, OFFER, ACK} state_e;
   state_e state_q, state_d;
   logic [TsWidth-1:0] dl_q [StackDepth];
   logic [TsWidth-1:0] dl_d [StackDepth];
   logic [DepWidth-1:0] depth_q, depth_d, top_idx;
   logic [IdWidth-1:0] offer_id_q, offer_id_d, core_id_q, core_id_d, ack_id_q, ack_id_d;
   logic [TsWidth-1:0] offer_dl_q, offer_dl_d, top_dl, diff;
   logic irq_q, irq_d, ack_q, ack_d, err_q, err_d, eligible, push, pop, load;
   always_comb begin
      top_idx    = depth_q - DepWidth'(1);
      top_dl     = (depth_q == '0) ? '0 : dl_q[top_idx[DepWidth-2:0]];
      // wrap-safe: the sign of the modular difference decides, ties never preempt
      diff       = ic_dl_i - top_dl;
      eligible   = ic_valid_i && (depth_q < DepWidth'(StackDepth)) && ((depth_q == '0) || diff[TsWidth-1]);
      pop        = core_complete_i && (depth_q != '0);
      // a coinciding complete wins over the claim
      push       = (state_q == OFFER) && core_claim_i && !core_complete_i;
      state_d    = (state_q == ACK) ? IDLE : push ? ACK : eligible ? OFFER : IDLE;
      load       = (state_q != ACK) && !push && eligible;
      offer_id_d = load ? ic_id_i : offer_id_q;
      offer_dl_d = load ? ic_dl_i : offer_dl_q;
      depth_d    = push ? depth_q + DepWidth'(1) : pop ? depth_q - DepWidth'(1) : depth_q;
      dl_d       = dl_q;
      if (push) dl_d[depth_q[DepWidth-2:0]] = offer_dl_q;
      err_d      = err_q || (core_complete_i && (depth_q == '0));
      irq_d      = (state_d == OFFER);
      core_id_d  = (state_d == OFFER) ? offer_id_d : '0;
      ack_d      = (state_d == ACK);
      ack_id_d   = (state_d == ACK) ? offer_id_q : '0;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         dl_q       <= '{default: '0};
         depth_q    <= '0;
         offer_id_q <= '0;
         offer_dl_q <= '0;
         irq_q      <= 1'b0;
         core_id_q  <= '0;
         ack_q      <= 1'b0;
         ack_id_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         dl_q       <= dl_d;
         depth_q    <= depth_d;
         offer_id_q <= offer_id_d;
         offer_dl_q <= offer_dl_d;
         irq_q      <= irq_d;
         core_id_q  <= core_id_d;
         ack_q      <= ack_d;
         ack_id_q   <= ack_id_d;
         err_q      <= err_d;
      end
   end
   assign ic_ack_o    = ack_q;
   assign ic_ack_id_o = ack_id_q;
   assign core_irq_o  = irq_q;
   assign core_id_o   = core_id_q;
   assign active_dl_o = top_dl;
   assign depth_o     = depth_q;
   assign err_o       = err_q;
endmodule

// File: tb/tb_edf_preempt_ctrl.sv
// tb_edf_preempt_ctrl: directed self-checking bench for edf_preempt_ctrl.
module tb_edf_preempt_ctrl;
   logic clk_i = 1'b0, rst_ni = 1'b0;
   logic ic_valid_i = 1'b0, core_claim_i = 1'b0, core_complete_i = 1'b0;
   logic [1:0] ic_id_i = '0;
   logic [23:0] ic_dl_i = '0;
   logic ic_ack_o, core_irq_o, err_o;
   logic [1:0] ic_ack_id_o, core_id_o;
   logic [23:0] active_dl_o;
   logic [2:0] depth_o;
   int checks = 0, errors = 0;
   edf_preempt_ctrl dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .ic_valid_i(ic_valid_i), .ic_id_i(ic_id_i), .ic_dl_i(ic_dl_i),
      .ic_ack_o(ic_ack_o), .ic_ack_id_o(ic_ack_id_o), .core_irq_o(core_irq_o), .core_id_o(core_id_o),
      .core_claim_i(core_claim_i), .core_complete_i(core_complete_i), .active_dl_o(active_dl_o),
      .depth_o(depth_o), .err_o(err_o)
   );
   always #5 clk_i = ~clk_i;
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic do_reset();
      rst_ni = 1'b0;
      ic_valid_i = 1'b0; core_claim_i = 1'b0; core_complete_i = 1'b0;
      step();
      rst_ni = 1'b1;
   endtask
   task automatic push(input logic [1:0] id, input logic [23:0] dl, input logic [2:0] exp_depth);
      ic_valid_i = 1'b1; ic_id_i = id; ic_dl_i = dl;
      step();
      chk("push_irq", {31'd0, core_irq_o}, 1);
      chk("push_core_id", {30'd0, core_id_o}, {30'd0, id});
      core_claim_i = 1'b1;
      step();
      core_claim_i = 1'b0; ic_valid_i = 1'b0;
      chk("push_ack", {30'd0, ic_ack_o, core_irq_o}, 32'b10);
      chk("push_ack_id", {30'd0, ic_ack_id_o}, {30'd0, id});
      chk("push_depth", {29'd0, depth_o}, {29'd0, exp_depth});
      chk("push_active_dl", {8'd0, active_dl_o}, {8'd0, dl});
      step();
      chk("push_ack_done", {31'd0, ic_ack_o}, 0);
   endtask
   initial begin
      do_reset();
      chk("rst_outputs", {ic_ack_o, core_irq_o, err_o, ic_ack_id_o, core_id_o, depth_o}, 0);
      chk("rst_active_dl", {8'd0, active_dl_o}, 0);
      push(2'd2, 24'h000100, 3'd1);
      ic_valid_i = 1'b1; ic_id_i = 2'd3; ic_dl_i = 24'h000100;
      step();
      chk("equal_dl_no_offer", {31'd0, core_irq_o}, 0);
      push(2'd1, 24'h000080, 3'd2);
      ic_valid_i = 1'b1; ic_id_i = 2'd3; ic_dl_i = 24'h000100;
      step(); step();
      chk("later_dl_100_no_offer", {31'd0, core_irq_o}, 0);
      ic_dl_i = 24'h000200;
      step(); step();
      chk("later_dl_200_no_offer", {31'd0, core_irq_o}, 0);
      chk("depth_two_kept", {29'd0, depth_o}, 2);
      do_reset();
      push(2'd0, 24'hFFFFF0, 3'd1);
      ic_valid_i = 1'b1; ic_id_i = 2'd1; ic_dl_i = 24'h000010;
      step(); step();
      chk("wrap_not_earlier", {31'd0, core_irq_o}, 0);
      do_reset();
      push(2'd0, 24'h000010, 3'd1);
      ic_valid_i = 1'b1; ic_id_i = 2'd3; ic_dl_i = 24'hFFFFF0;
      step();
      chk("wrap_earlier_offer", {29'd0, core_irq_o, core_id_o}, 32'b111);
      do_reset();
      push(2'd0, 24'h000400, 3'd1);
      push(2'd1, 24'h000300, 3'd2);
      push(2'd2, 24'h000200, 3'd3);
      push(2'd3, 24'h000100, 3'd4);
      ic_valid_i = 1'b1; ic_id_i = 2'd1; ic_dl_i = 24'h000050;
      step(); step();
      chk("full_no_offer", {31'd0, core_irq_o}, 0);
      core_complete_i = 1'b1;
      step();
      core_complete_i = 1'b0;
      chk("pop_depth3", {29'd0, depth_o}, 3);
      chk("pop_active_dl", {8'd0, active_dl_o}, 32'h200);
      step();
      chk("offer_resumes", {29'd0, core_irq_o, core_id_o}, 32'b101);
      ic_valid_i = 1'b0;
      step();
      chk("offer_withdrawn", {31'd0, core_irq_o}, 0);
      do_reset();
      core_complete_i = 1'b1;
      step();
      core_complete_i = 1'b0;
      chk("err_set", {28'd0, err_o, depth_o}, 32'b1000);
      step();
      chk("err_sticky", {31'd0, err_o}, 1);
      push(2'd2, 24'h000100, 3'd1);
      ic_valid_i = 1'b1; ic_id_i = 2'd3; ic_dl_i = 24'h000080;
      step();
      chk("coincide_offer", {31'd0, core_irq_o}, 1);
      core_claim_i = 1'b1; core_complete_i = 1'b1;
      step();
      core_claim_i = 1'b0; core_complete_i = 1'b0; ic_valid_i = 1'b0;
      chk("coincide_no_ack", {31'd0, ic_ack_o}, 0);
      chk("coincide_pop", {29'd0, depth_o}, 0);
      step();
      chk("coincide_still_no_ack", {30'd0, ic_ack_o, core_irq_o}, 0);
      do_reset();
      push(2'd2, 24'h000100, 3'd1);
      ic_valid_i = 1'b1; ic_id_i = 2'd1; ic_dl_i = 24'h000040;
      step();
      core_claim_i = 1'b1;
      step();
      core_claim_i = 1'b0; ic_valid_i = 1'b0;
      chk("ack_before_reset", {30'd0, ic_ack_o, ic_ack_id_o[0]}, 32'b11);
      rst_ni = 1'b0;
      #1;
      chk("async_rst_outputs", {ic_ack_o, core_irq_o, err_o, ic_ack_id_o, core_id_o, depth_o}, 0);
      chk("async_rst_active_dl", {8'd0, active_dl_o}, 0);
      step();
      rst_ni = 1'b1;
      step();
      chk("no_ack_after_release", {30'd0, ic_ack_o, core_irq_o}, 0);
      step();
      chk("no_ack_after_release2", {29'd0, ic_ack_o, depth_o[1:0]}, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/edf_preempt_ctrl.md
EDF_PREEMPT_CTRL -- requirements
Module: edf_preempt_ctrl

Interface
REQ-001 The block SHALL have parameter NrIrqs, default 4, meaning number of interrupt lines served by the EDF interrupt controller.
REQ-002 The block SHALL have parameter TsWidth, default 24, meaning deadline timestamp width.
REQ-003 The block SHALL have parameter StackDepth, default 4, meaning maximum nesting depth (power of two, >=2).
REQ-004 The block SHALL have localparams IdWidth = $clog2(NrIrqs) and DepWidth = $clog2(StackDepth)+1.
REQ-005 The block SHALL have port clk_i, input, 1, clock; all state rising-edge.
REQ-006 The block SHALL have port rst_ni, input, 1, reset, asynchronous, active-low.
REQ-007 The block SHALL have port ic_valid_i, input, 1, controller has an enabled pending winner.
REQ-008 The block SHALL have port ic_id_i, input, IdWidth, winner line index.
REQ-009 The block SHALL have port ic_dl_i, input, TsWidth, winner absolute deadline.
REQ-010 The block SHALL have port ic_ack_o, output, 1, single-cycle claim pulse to controller.
REQ-011 The block SHALL have port ic_ack_id_o, output, IdWidth, id claimed with ic_ack_o.
REQ-012 The block SHALL have port core_irq_o, output, 1, interrupt offered to core.
REQ-013 The block SHALL have port core_id_o, output, IdWidth, offered id.
REQ-014 The block SHALL have port core_claim_i, input, 1, core takes the offered interrupt (1-cycle pulse).
REQ-015 The block SHALL have port core_complete_i, input, 1, core finished current handler (1-cycle pulse).
REQ-016 The block SHALL have port active_dl_o, output, TsWidth, deadline on top of stack (0 when empty).
REQ-017 The block SHALL have port depth_o, output, DepWidth, current nesting depth.
REQ-018 The block SHALL have port err_o, output, 1, sticky: complete received with empty stack.

Function
REQ-019 The block SHALL compute eligible = ic_valid_i & (depth<StackDepth) & (depth==0 | earlier(ic_dl_i, top_dl)).
REQ-020 The block SHALL define earlier(a,b) as bit TsWidth-1 of (a-b) mod 2^TsWidth being 1 (wrap-safe signed difference); equal deadlines SHALL NOT preempt.
REQ-021 The block SHALL implement FSM states IDLE, OFFER, ACK.
REQ-022 In IDLE, when eligible, the block SHALL register ic_id_i/ic_dl_i into offer registers and go to OFFER; core_irq_o SHALL be 1 exactly while in OFFER, with core_id_o driven from the offer register.
REQ-023 In OFFER without claim, the block SHALL re-register id/dl each cycle eligible holds and SHALL return to IDLE the cycle after eligible drops.
REQ-024 In OFFER with core_claim_i, the block SHALL push {offer id, offer dl} (registered values, not current inputs) and go to ACK.
REQ-025 In ACK, the block SHALL assert ic_ack_o=1 with ic_ack_id_o=pushed id for exactly one cycle, then go to IDLE; no offer SHALL be made in ACK.
REQ-026 Claim latency: ic_ack_o SHALL rise one cycle after the core_claim_i cycle; depth_o/active_dl_o SHALL update in that same cycle.
REQ-027 core_complete_i with depth>0 SHALL pop the top entry in any state; with depth==0 it SHALL set err_o and leave the stack unchanged.
REQ-028 When core_complete_i and core_claim_i coincide in OFFER, the block SHALL apply the pop only, ignore the claim, and re-evaluate eligibility against the new top next cycle.
REQ-029 core_claim_i outside OFFER SHALL be ignored.
REQ-030 When depth==StackDepth, the block SHALL make no offer regardless of deadline.
REQ-031 ic_ack_o and core_irq_o SHALL never be 1 in the same cycle.
REQ-032 The block SHALL drive ic_ack_id_o and core_id_o to 0 when their strobes are low.

Reset
REQ-033 On rst_ni low, the block SHALL asynchronously enter IDLE, clear stack, depth_o=0, active_dl_o=0, core_irq_o=0, core_id_o=0, ic_ack_o=0, ic_ack_id_o=0, err_o=0.
REQ-034 Reset during OFFER or ACK SHALL abort the transaction; no ic_ack_o SHALL be emitted after reset release for the aborted claim.

Verification
REQ-035 Bench SHALL cover: idle, ic_valid_i=1 id=2 dl=0x000100 -> core_irq_o=1 id=2 next cycle; claim -> ic_ack_o pulse id=2, depth_o=1, active_dl_o=0x000100.
REQ-036 Bench SHALL cover: active dl=0x000100, winner id=1 dl=0x000080 -> offered and pushed, depth_o=2; winner dl=0x000100 or 0x000200 -> no offer.
REQ-037 Bench SHALL cover: wrap, active dl=0xFFFFF0, winner dl=0x000010 -> not earlier, no offer; active dl=0x000010, winner dl=0xFFFFF0 -> offered.
REQ-038 Bench SHALL cover: fill to depth 4 with strictly decreasing deadlines -> fifth earlier winner not offered; one complete -> depth_o=3, offer resumes.
REQ-039 Bench SHALL cover: complete at depth 0 -> err_o=1 and sticky; claim and complete same cycle in OFFER -> pop only, no ic_ack_o.
REQ-040 Bench SHALL cover: rst_ni low in ACK -> all outputs 0 immediately, no ack after release.
